// File: rtl/arp_query_gen.sv
// Parses Ethernet/IPv4 headers from the MAC receive stream and issues one
// ARP cache query per valid IPv4 frame, with accepted/dropped frame counters.
module arp_query_gen #(
    parameter int unsigned CNT_W         = 32,
    parameter bit          CHECK_VERSION = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    input  logic             rx_sop_i,
    input  logic             rx_eop_i,
    input  logic [1:0]       rx_empty_i,
    input  logic [5:0]       rx_error_i,
    output logic             query_req_valid_o,
    input  logic             query_req_ready_i,
    output logic [31:0]      query_ip_o,
    output logic [CNT_W-1:0] stat_ok_o,
    output logic [CNT_W-1:0] stat_drop_o
);

    localparam int unsigned    W_W      = 4;
    localparam logic [W_W-1:0] W_MAX    = W_W'(9);
    localparam logic [15:0]    ETH_IPV4 = 16'h0800;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_EMIT,
        S_DRAIN
    } state_t;

    state_t           r_state;
    logic [W_W-1:0]   r_w;
    logic [15:0]      r_w7_lo;
    logic             r_rx_ready;
    logic             r_q_valid;
    logic [31:0]      r_q_ip;
    logic             r_eop_seen;
    logic             r_issued;
    logic [CNT_W-1:0] r_ok;
    logic [CNT_W-1:0] r_drop;

    logic             w_take;
    logic             w_err;
    logic             w_bad_type;
    logic             w_short;
    logic             w_hdr_drop;
    logic             w_sop_bad;
    logic [W_W-1:0]   w_w_inc;
    logic [1:0]       w_drop_inc;

    assign w_take     = rx_valid_i && r_rx_ready;
    assign w_err      = |rx_error_i;
    assign w_bad_type = (r_w == W_W'(3)) &&
                        ((rx_data_i[31:16] != ETH_IPV4) ||
                         (CHECK_VERSION && (rx_data_i[15:12] != 4'd4)));
    // The w8 beat must still carry the two low destination-address bytes.
    assign w_short    = rx_eop_i && ((r_w < W_W'(8)) ||
                                     ((r_w == W_W'(8)) && (rx_empty_i == 2'd3)));
    assign w_hdr_drop = w_err || w_bad_type || w_short;
    assign w_sop_bad  = rx_eop_i || w_err;
    assign w_w_inc    = (r_w == W_MAX) ? W_MAX : r_w + W_W'(1);

    // A restarting SOP can retire the old frame and the new one in one beat.
    always_comb begin
        w_drop_inc = 2'd0;
        if (w_take) begin
            case (r_state)
                S_IDLE:  if (rx_sop_i && w_sop_bad) w_drop_inc = 2'd1;
                S_HDR: begin
                    if (rx_sop_i)        w_drop_inc = w_sop_bad ? 2'd2 : 2'd1;
                    else if (w_hdr_drop) w_drop_inc = 2'd1;
                end
                S_DRAIN: if (rx_sop_i) w_drop_inc = 2'(!r_issued) + 2'(w_sop_bad);
                default: w_drop_inc = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_w        <= '0;
            r_w7_lo    <= '0;
            r_rx_ready <= 1'b1;
            r_q_valid  <= 1'b0;
            r_q_ip     <= '0;
            r_eop_seen <= 1'b0;
            r_issued   <= 1'b0;
            r_ok       <= '0;
            r_drop     <= '0;
        end else begin
            r_drop <= r_drop + CNT_W'(w_drop_inc);
            case (r_state)
                S_IDLE: begin
                    if (w_take && rx_sop_i) begin
                        r_w <= W_W'(1);
                        if (!w_sop_bad) r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_take) begin
                        if (rx_sop_i) begin
                            r_w <= W_W'(1);
                            if (w_sop_bad) r_state <= S_IDLE;
                        end else if (w_hdr_drop) begin
                            r_w      <= w_w_inc;
                            r_issued <= 1'b0;
                            r_state  <= rx_eop_i ? S_IDLE : S_DRAIN;
                        end else if (r_w == W_W'(8)) begin
                            r_w        <= w_w_inc;
                            r_q_ip     <= {r_w7_lo, rx_data_i[31:16]};
                            r_q_valid  <= 1'b1;
                            r_rx_ready <= 1'b0;
                            r_eop_seen <= rx_eop_i;
                            r_state    <= S_EMIT;
                        end else begin
                            r_w <= w_w_inc;
                            if (r_w == W_W'(7)) r_w7_lo <= rx_data_i[15:0];
                        end
                    end
                end
                S_EMIT: begin
                    if (query_req_ready_i) begin
                        r_q_valid  <= 1'b0;
                        r_rx_ready <= 1'b1;
                        r_ok       <= r_ok + CNT_W'(1);
                        r_issued   <= 1'b1;
                        r_state    <= r_eop_seen ? S_IDLE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_take) begin
                        if (rx_sop_i) begin
                            r_w     <= W_W'(1);
                            r_state <= w_sop_bad ? S_IDLE : S_HDR;
                        end else if (rx_eop_i) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_w <= w_w_inc;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_ready_o        = r_rx_ready;
    assign query_req_valid_o = r_q_valid;
    assign query_ip_o        = r_q_ip;
    assign stat_ok_o         = r_ok;
    assign stat_drop_o       = r_drop;

endmodule

// File: tb/tb_arp_query_gen.sv
// Bench for arp_query_gen: frame-level outcome model plus per-cycle query port checks.
module tb_arp_query_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        rx_sop_i;
    logic        rx_eop_i;
    logic [1:0]  rx_empty_i;
    logic [5:0]  rx_error_i;
    logic        query_req_valid_o;
    logic        query_req_ready_i = 1'b1;
    logic [31:0] query_ip_o;
    logic [31:0] stat_ok_o;
    logic [31:0] stat_drop_o;

    always #5 clk = ~clk;

    arp_query_gen #(.CNT_W(32), .CHECK_VERSION(1'b1)) dut (
        .clk               (clk),
        .rst               (rst),
        .rx_data_i         (rx_data_i),
        .rx_valid_i        (rx_valid_i),
        .rx_ready_o        (rx_ready_o),
        .rx_sop_i          (rx_sop_i),
        .rx_eop_i          (rx_eop_i),
        .rx_empty_i        (rx_empty_i),
        .rx_error_i        (rx_error_i),
        .query_req_valid_o (query_req_valid_o),
        .query_req_ready_i (query_req_ready_i),
        .query_ip_o        (query_ip_o),
        .stat_ok_o         (stat_ok_o),
        .stat_drop_o       (stat_drop_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fw [16];
    logic [5:0]  fe [16];
    logic [31:0] exp_q [$];
    int          exp_ok = 0;
    int          exp_drop = 0;
    bit          pending = 1'b0;
    bit          chk_en = 1'b0;
    bit          expect_rise = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_hs = 1'b0;
    int          low_run = 0;
    int          last_low = 0;
    int          stall_cycles = 0;
    int          stall_cnt = 0;
    logic [31:0] ip;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outcome of one SOP-led segment, decided from the frame contents alone.
    function automatic void model_frame(input int n, input bit has_eop, input logic [1:0] emp,
                                        output bit q, output logic [31:0] qip,
                                        output bit dr, output bit cl);
        logic [31:0] w3;
        bit          last;
        q = 1'b0; qip = '0; dr = 1'b0; cl = has_eop;
        if ((has_eop && n == 1) || fe[0] != 6'd0) begin
            dr = 1'b1; cl = 1'b1;
            return;
        end
        w3 = fw[3];
        for (int i = 1; i < n; i++) begin
            last = has_eop && (i == n - 1);
            if (fe[i] != 6'd0 || (i == 3 && (w3[31:16] != 16'h0800 || w3[15:12] != 4'h4)) ||
                (last && (i < 8 || emp == 2'd3))) begin
                dr = 1'b1;
                return;
            end
            if (i == 8) begin
                q   = 1'b1;
                qip = {fw[7][15:0], fw[8][31:16]};
                return;
            end
        end
    endfunction

    task automatic set_ipv4(input logic [31:0] dip);
        for (int i = 0; i < 16; i++) begin
            fw[i] = 32'h5A00_0000 | 32'(i);
            fe[i] = 6'd0;
        end
        fw[0] = 32'hFFFF_FFFF;
        fw[1] = 32'hFFFF_0011;
        fw[2] = 32'h2233_4455;
        fw[3] = 32'h0800_4500;
        fw[4] = 32'h0040_0000;
        fw[5] = 32'h4000_4011;
        fw[6] = 32'h0000_C0A8;
        fw[7] = {16'h0101, dip[31:16]};
        fw[8] = {dip[15:0], 16'h1234};
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                             input logic [5:0] err, input logic [1:0] emp, input bit w8mark);
        bit tk;
        bit done;
        done = 1'b0;
        rx_data_i = d; rx_sop_i = sop; rx_eop_i = eop; rx_error_i = err; rx_empty_i = emp;
        rx_valid_i = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            tk = rx_ready_o;
            @(posedge clk);
            #1;
            if (tk) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL beat_accept: beat %0h never taken, required taken within 200 cycles", d);
        end
        if (w8mark) expect_rise = 1'b1;
        rx_valid_i = 1'b0; rx_sop_i = 1'b0; rx_eop_i = 1'b0; rx_error_i = '0; rx_empty_i = '0;
    endtask

    task automatic send_frame(input int n, input bit has_eop, input logic [1:0] emp,
                              input int upto, output logic [31:0] ip_o);
        bit          q, dr, cl;
        logic [31:0] qip;
        bit          e;
        model_frame(n, has_eop, emp, q, qip, dr, cl);
        if (pending) exp_drop++;
        exp_drop += int'(dr);
        if (q) exp_q.push_back(qip);
        pending = !cl && !q;
        for (int i = 0; i < upto; i++) begin
            e = has_eop && (i == n - 1);
            send_beat(fw[i], i == 0, e, fe[i], e ? emp : 2'd0, q && i == 8);
        end
        ip_o = qip;
    endtask

    task automatic settle(input string nm);
        repeat (10) @(posedge clk);
        #1;
        check({nm, "_drop"}, stat_drop_o, exp_drop);
        check({nm, "_ok"}, stat_ok_o, exp_ok);
        check({nm, "_qempty"}, exp_q.size(), 0);
    endtask

    // ARP cache side: accept after stall_cycles cycles of valid.
    always @(posedge clk) begin
        #1;
        if (query_req_valid_o) begin
            if (stall_cnt < stall_cycles) begin
                query_req_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                query_req_ready_i = 1'b1;
            end
        end else begin
            stall_cnt = 0;
            query_req_ready_i = (stall_cycles == 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("stat_ok", stat_ok_o, exp_ok);
            if (query_req_valid_o) begin
                check("query_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("query_ip", query_ip_o, exp_q[0]);
            end
            if (expect_rise) begin
                check("query_latency", {prev_valid, query_req_valid_o}, 2'b01);
                expect_rise = 1'b0;
            end
            if (prev_valid && !prev_hs) check("valid_held", query_req_valid_o, 1);
            prev_hs = query_req_valid_o && query_req_ready_i;
            if (prev_hs) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                exp_ok++;
            end
            if (!rx_ready_o) low_run++;
            else if (low_run > 0) begin
                last_low = low_run;
                low_run  = 0;
            end
            prev_valid = query_req_valid_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        rx_data_i = '0; rx_valid_i = 1'b0; rx_sop_i = 1'b0; rx_eop_i = 1'b0;
        rx_empty_i = '0; rx_error_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_rx_ready", rx_ready_o, 1);
        check("rst_valid", query_req_valid_o, 0);
        check("rst_ip", query_ip_o, 0);
        check("rst_ok", stat_ok_o, 0);
        check("rst_drop", stat_drop_o, 0);
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Valid 64-byte IPv4 frame, immediate accept
        set_ipv4(32'h0);
        fw[7] = 32'hC0A8_0A01;
        fw[8] = 32'h0A00_0005;
        send_frame(16, 1'b1, 2'd0, 16, ip);
        check("t1_model_ip", ip, 32'h0A01_0A00);
        settle("t1");
        check("t1_ok_lit", stat_ok_o, 1);
        check("t1_rdy_low", last_low, 1);

        // Same frame, ARP cache stalls 5 cycles
        stall_cycles = 5;
        send_frame(16, 1'b1, 2'd0, 16, ip);
        settle("t2");
        stall_cycles = 0;
        check("t2_ok_lit", stat_ok_o, 2);
        check("t2_rdy_low", last_low, 6);

        // ARP Ethertype
        set_ipv4(32'h0A00_0003);
        fw[3] = 32'h0806_0001;
        send_frame(16, 1'b1, 2'd0, 16, ip);
        settle("t3");
        check("t3_drop_lit", stat_drop_o, 1);

        // EOP at w5, then a normal frame
        set_ipv4(32'h0A00_0001);
        send_frame(6, 1'b1, 2'd1, 6, ip);
        set_ipv4(32'h0A00_0002);
        send_frame(16, 1'b1, 2'd0, 16, ip);
        settle("t4");
        check("t4_drop_lit", stat_drop_o, 2);
        check("t4_ok_lit", stat_ok_o, 3);

        // Error on w4, SOP arrives while draining
        set_ipv4(32'h0A00_0033);
        fe[4] = 6'h01;
        send_frame(10, 1'b0, 2'd0, 10, ip);
        set_ipv4(32'h0A00_0004);
        send_frame(16, 1'b1, 2'd0, 16, ip);
        settle("t5");
        check("t5_drop_lit", stat_drop_o, 4);
        check("t5_ok_lit", stat_ok_o, 4);

        // Truncated in header by SOP, then frame ending exactly on w8
        set_ipv4(32'h0A00_0005);
        send_frame(5, 1'b0, 2'd0, 5, ip);
        set_ipv4(32'hAC10_0106);
        send_frame(9, 1'b1, 2'd2, 9, ip);
        check("t6_model_ip", ip, 32'hAC10_0106);
        settle("t6");
        check("t6_drop_lit", stat_drop_o, 5);

        // Query issued, then SOP in drain: no extra drop
        set_ipv4(32'h0A00_0007);
        send_frame(12, 1'b0, 2'd0, 12, ip);
        set_ipv4(32'h0A00_0008);
        send_frame(16, 1'b1, 2'd0, 16, ip);
        settle("t7");
        check("t7_drop_lit", stat_drop_o, 5);
        check("t7_ok_lit", stat_ok_o, 7);

        // Error on w8, bad version, short w8 EOP
        set_ipv4(32'h0A00_0009);
        fe[8] = 6'h20;
        send_frame(16, 1'b1, 2'd0, 16, ip);
        set_ipv4(32'h0A00_000A);
        fw[3] = 32'h0800_6500;
        send_frame(16, 1'b1, 2'd0, 16, ip);
        set_ipv4(32'h0A00_000B);
        send_frame(9, 1'b1, 2'd3, 9, ip);
        settle("t8");
        check("t8_drop_lit", stat_drop_o, 8);

        // Orphan beats, SOP with error, then normal frame
        send_beat(32'hDEAD_BEEF, 1'b0, 1'b0, 6'd0, 2'd0, 1'b0);
        send_beat(32'h0800_4500, 1'b0, 1'b1, 6'd0, 2'd0, 1'b0);
        set_ipv4(32'h0A00_000C);
        fe[0] = 6'h02;
        send_frame(16, 1'b1, 2'd0, 16, ip);
        set_ipv4(32'h0A00_000D);
        send_frame(16, 1'b1, 2'd0, 16, ip);
        settle("t9");
        check("t9_drop_lit", stat_drop_o, 9);
        check("t9_ok_lit", stat_ok_o, 8);

        // Reset while a query is pending
        stall_cycles = 1000;
        set_ipv4(32'h0A00_00AA);
        send_frame(16, 1'b1, 2'd0, 9, ip);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        stall_cycles = 0;
        @(negedge clk);
        check("t10_valid", query_req_valid_o, 0);
        check("t10_ip", query_ip_o, 0);
        check("t10_rx_ready", rx_ready_o, 1);
        check("t10_ok", stat_ok_o, 0);
        check("t10_drop", stat_drop_o, 0);
        exp_q.delete();
        exp_ok = 0; exp_drop = 0; pending = 1'b0;
        prev_valid = 1'b0; prev_hs = 1'b0; expect_rise = 1'b0; low_run = 0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 9; i < 16; i++) send_beat(fw[i], 1'b0, i == 15, 6'd0, 2'd0, 1'b0);
        set_ipv4(32'h0A00_00BB);
        send_frame(16, 1'b1, 2'd0, 16, ip);
        settle("t10");
        check("t10_ok_lit", stat_ok_o, 1);
        check("t10_drop_lit", stat_drop_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
